// File: rtl/uart_bus_bridge.sv
// Host debug/loader bridge: UART byte frames in, picorv32 native-bus transactions out, reply bytes back.
// Define UART_BRIDGE_AUTOINC_EN to add the 'N' auto-increment write command.
module uart_bus_bridge #(
   parameter int BUS_TIMEOUT = 1024,
   parameter int RX_TIMEOUT  = 720000
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic        mem_valid,
   output logic        mem_instr,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wstrb,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ready,
   output logic        busy,
   output logic        overrun
);

   // state   | meaning
   // S_IDLE  | waiting for a command byte
   // S_ARGS  | collecting operand bytes (address and/or data)
   // S_BUS   | bus request outstanding (mem_valid high)
   // S_REPLY | presenting reply bytes to the transmitter

   typedef enum logic [1:0] {S_IDLE, S_ARGS, S_BUS, S_REPLY} state_t;
   typedef enum logic [1:0] {C_WR, C_RD, C_INC, C_BAD} cmd_t;

   localparam int BT_W = (BUS_TIMEOUT > 1) ? $clog2(BUS_TIMEOUT + 1) : 1;
   localparam int RT_W = (RX_TIMEOUT > 1) ? $clog2(RX_TIMEOUT + 1) : 1;

   state_t          state, state_nxt;
   cmd_t            cmd, cmd_dec;
   logic [3:0]      byte_cnt;
   logic [31:0]     reply_buf;
   logic [BT_W-1:0] bus_timer;
   logic [RT_W-1:0] rx_timer;
   logic            last_arg, bus_expire, rx_expire, tx_accept, last_reply;
   logic [4:0]      byte_lsb;

   always_comb begin
      cmd_dec = C_BAD;
      case (rx_data)
         8'h57:   cmd_dec = C_WR;
         8'h52:   cmd_dec = C_RD;
`ifdef UART_BRIDGE_AUTOINC_EN
         8'h4E:   cmd_dec = C_INC;
`endif
         default: cmd_dec = C_BAD;
      endcase
   end

   assign byte_lsb   = {byte_cnt[1:0], 3'b000};
   assign last_arg   = rx_valid && (byte_cnt == ((cmd == C_WR) ? 4'd7 : 4'd3));
   assign bus_expire = (BUS_TIMEOUT != 0) && !mem_ready && (bus_timer == BT_W'(1));
   assign rx_expire  = (RX_TIMEOUT != 0) && !rx_valid && (rx_timer == RT_W'(1));
   assign tx_accept  = tx_valid && tx_ready;
   assign last_reply = (byte_cnt == 4'd0);

`ifdef UART_BRIDGE_AUTOINC_EN
   logic [31:0] last_addr;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)
         last_addr <= 32'h0;
      else if (state == S_BUS && mem_ready && cmd != C_RD)
         last_addr <= mem_addr;
   end
`endif

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)
         state <= S_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (rx_valid) state_nxt = (cmd_dec == C_BAD) ? S_REPLY : S_ARGS;
         S_ARGS: begin
            if (last_arg)
               state_nxt = S_BUS;
            else if (rx_expire)
               state_nxt = S_IDLE;
         end
         S_BUS:   if (mem_ready || bus_expire) state_nxt = S_REPLY;
         S_REPLY: if (tx_accept && last_reply) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Bus and reply strobes derive from state so an async reset drops them at once.
   always_comb begin
      busy      = (state != S_IDLE);
      mem_valid = (state == S_BUS);
      mem_instr = 1'b0;
      mem_wstrb = (state == S_BUS && cmd != C_RD) ? 4'hF : 4'h0;
      tx_valid  = (state == S_REPLY);
      tx_data   = tx_valid ? reply_buf[7:0] : 8'h00;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cmd       <= C_BAD;
         byte_cnt  <= 4'd0;
         mem_addr  <= 32'h0;
         mem_wdata <= 32'h0;
         reply_buf <= 32'h0;
         bus_timer <= '0;
         rx_timer  <= '0;
         overrun   <= 1'b0;
      end else begin
         if (rx_valid && (state == S_BUS || state == S_REPLY))
            overrun <= 1'b1;
         case (state)
            S_IDLE: begin
               if (rx_valid) begin
                  cmd       <= cmd_dec;
                  byte_cnt  <= 4'd0;
                  rx_timer  <= RT_W'(RX_TIMEOUT);
                  reply_buf <= 32'h15;
               end
            end
            S_ARGS: begin
               if (rx_valid) begin
                  rx_timer <= RT_W'(RX_TIMEOUT);
                  if (cmd == C_INC || byte_cnt[2])
                     mem_wdata[byte_lsb +: 8] <= rx_data;
                  else if (byte_cnt[1:0] == 2'd0)
                     mem_addr[7:0] <= {rx_data[7:2], 2'b00};
                  else
                     mem_addr[byte_lsb +: 8] <= rx_data;
                  if (byte_cnt != 4'hF)
                     byte_cnt <= byte_cnt + 4'd1;
                  if (last_arg)
                     bus_timer <= BT_W'(BUS_TIMEOUT);
`ifdef UART_BRIDGE_AUTOINC_EN
                  if (last_arg && cmd == C_INC)
                     mem_addr <= last_addr + 32'd4;
`endif
               end else if (rx_timer != '0) begin
                  rx_timer <= rx_timer - 1'b1;
               end
            end
            S_BUS: begin
               if (mem_ready) begin
                  reply_buf <= (cmd == C_RD) ? mem_rdata : 32'h06;
                  byte_cnt  <= (cmd == C_RD) ? 4'd3 : 4'd0;
               end else if (bus_expire) begin
                  reply_buf <= 32'h15;
                  byte_cnt  <= 4'd0;
               end else if (bus_timer != '0) begin
                  bus_timer <= bus_timer - 1'b1;
               end
            end
            S_REPLY: begin
               if (tx_accept) begin
                  reply_buf <= {8'h00, reply_buf[31:8]};
                  if (byte_cnt != 4'd0)
                     byte_cnt <= byte_cnt - 4'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_bus_bridge.sv
// Directed bench for uart_bus_bridge: frames in, bus cycles and reply bytes checked against hand values.
module tb_uart_bus_bridge;

   typedef logic [7:0] byte_q_t[$];

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_valid = 1'b0;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready = 1'b0;
   logic        mem_valid;
   logic        mem_instr;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_rdata = 32'h0;
   logic        mem_ready = 1'b0;
   logic        busy;
   logic        overrun;

   int n_pass = 0;
   int n_total = 0;

   bit          resp_en = 1'b1;
   int          resp_lat = 2;
   int          resp_wait = 0;
   logic [31:0] resp_rdata = 32'h0;
   int          n_txn = 0;
   int          valid_cycles = 0;
   logic [31:0] log_addr = 32'h0;
   logic [31:0] log_wdata = 32'h0;
   logic [3:0]  log_wstrb = 4'h0;

   always #5 clk = ~clk;

   uart_bus_bridge #(.BUS_TIMEOUT(16), .RX_TIMEOUT(100)) dut (
      .clk(clk), .resetn(resetn),
      .rx_data(rx_data), .rx_valid(rx_valid),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
      .mem_ready(mem_ready), .busy(busy), .overrun(overrun)
   );

   // Bus responder: answers resp_lat cycles after mem_valid rises, logs the accepted request.
   always @(negedge clk) begin
      mem_ready = 1'b0;
      if (mem_valid === 1'b1) begin
         valid_cycles++;
         if (resp_en) begin
            if (resp_wait >= resp_lat) begin
               mem_ready = 1'b1;
               mem_rdata = resp_rdata;
               n_txn++;
               log_addr  = mem_addr;
               log_wdata = mem_wdata;
               log_wstrb = mem_wstrb;
               resp_wait = 0;
            end else begin
               resp_wait++;
            end
         end
      end else begin
         resp_wait = 0;
      end
   end

   task automatic send_byte(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   task automatic send_frame(input byte_q_t f);
      foreach (f[i]) send_byte(f[i]);
   endtask

   task automatic get_byte(input int hold, output logic [7:0] b, output bit ok, output bit stable);
      int n = 0;
      ok = 1'b1;
      stable = 1'b1;
      b = 8'h00;
      while (tx_valid !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (tx_valid !== 1'b1) begin
         ok = 1'b0;
         return;
      end
      b = tx_data;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         if (tx_valid !== 1'b1 || tx_data !== b) stable = 1'b0;
      end
      tx_ready = 1'b1;
      @(negedge clk);
      tx_ready = 1'b0;
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      repeat (3) @(negedge clk);
      n_total++; if (tx_valid !== 1'b0) $display("FAIL reset_tx_valid got=%b exp=0", tx_valid); else n_pass++;
      n_total++; if (tx_data !== 8'h00) $display("FAIL reset_tx_data got=%h exp=00", tx_data); else n_pass++;
      n_total++; if (mem_valid !== 1'b0) $display("FAIL reset_mem_valid got=%b exp=0", mem_valid); else n_pass++;
      n_total++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) $display("FAIL reset_addr_data got=%h/%h exp=0/0", mem_addr, mem_wdata); else n_pass++;
      n_total++; if (mem_wstrb !== 4'h0 || mem_instr !== 1'b0) $display("FAIL reset_wstrb_instr got=%h/%b exp=0/0", mem_wstrb, mem_instr); else n_pass++;
      n_total++; if (busy !== 1'b0 || overrun !== 1'b0) $display("FAIL reset_busy_overrun got=%b/%b exp=0/0", busy, overrun); else n_pass++;
      resetn = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_write();
      byte_q_t f;
      logic [7:0] b;
      bit ok, st;
      int t0 = n_txn;
      f = '{8'h57, 8'h00, 8'h01, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
      send_frame(f);
      get_byte(0, b, ok, st);
      n_total++; if (!ok || b !== 8'h06) $display("FAIL write_reply got=%h ok=%0d exp=06", b, ok); else n_pass++;
      n_total++; if (n_txn - t0 !== 1) $display("FAIL write_txn_count got=%0d exp=1", n_txn - t0); else n_pass++;
      n_total++; if (log_addr !== 32'h0000_0100) $display("FAIL write_addr got=%h exp=00000100", log_addr); else n_pass++;
      n_total++; if (log_wdata !== 32'hDEAD_BEEF) $display("FAIL write_wdata got=%h exp=deadbeef", log_wdata); else n_pass++;
      n_total++; if (log_wstrb !== 4'hF) $display("FAIL write_wstrb got=%h exp=f", log_wstrb); else n_pass++;
      n_total++; if (busy !== 1'b0 || tx_valid !== 1'b0) $display("FAIL write_idle got=%b/%b exp=0/0", busy, tx_valid); else n_pass++;
   endtask

   task automatic test_read();
      byte_q_t f;
      logic [7:0] b;
      logic [7:0] exp_b [4] = '{8'h78, 8'h56, 8'h34, 8'h12};
      bit ok, st;
      bit all_st = 1'b1;
      resp_rdata = 32'h1234_5678;
      f = '{8'h52, 8'h00, 8'h01, 8'h00, 8'h00};
      send_frame(f);
      for (int i = 0; i < 4; i++) begin
         get_byte(5, b, ok, st);
         if (!st) all_st = 1'b0;
         n_total++; if (!ok || b !== exp_b[i]) $display("FAIL read_byte%0d got=%h ok=%0d exp=%h", i, b, ok, exp_b[i]); else n_pass++;
      end
      n_total++; if (!all_st) $display("FAIL read_tx_stable got=unstable exp=stable"); else n_pass++;
      n_total++; if (tx_valid !== 1'b0) $display("FAIL read_no_extra got=%b exp=0", tx_valid); else n_pass++;
      n_total++; if (log_wstrb !== 4'h0 || log_addr !== 32'h0000_0100) $display("FAIL read_bus got=%h/%h exp=0/00000100", log_wstrb, log_addr); else n_pass++;
   endtask

   task automatic test_unknown();
      logic [7:0] b;
      bit ok, st;
      int v0 = valid_cycles;
      send_byte(8'h41);
      get_byte(0, b, ok, st);
      n_total++; if (!ok || b !== 8'h15) $display("FAIL unknown_reply got=%h ok=%0d exp=15", b, ok); else n_pass++;
      n_total++; if (valid_cycles - v0 !== 0) $display("FAIL unknown_no_bus got=%0d exp=0", valid_cycles - v0); else n_pass++;
   endtask

   task automatic test_addr_mask();
      byte_q_t f;
      logic [7:0] b;
      bit ok, st;
      f = '{8'h57, 8'h03, 8'h01, 8'h00, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
      send_frame(f);
      get_byte(0, b, ok, st);
      n_total++; if (!ok || b !== 8'h06) $display("FAIL mask_reply got=%h ok=%0d exp=06", b, ok); else n_pass++;
      n_total++; if (log_addr !== 32'h0000_0100) $display("FAIL mask_addr got=%h exp=00000100", log_addr); else n_pass++;
      n_total++; if (log_wdata !== 32'h0403_0201) $display("FAIL mask_wdata got=%h exp=04030201", log_wdata); else n_pass++;
   endtask

   task automatic test_bus_timeout();
      byte_q_t f;
      logic [7:0] b;
      bit ok, st;
      int n = 0;
      int v0;
      resp_en = 1'b0;
      v0 = valid_cycles;
      f = '{8'h52, 8'h00, 8'h02, 8'h00, 8'h00};
      send_frame(f);
      while (tx_valid !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      n_total++; if (valid_cycles - v0 !== 16) $display("FAIL timeout_valid_cycles got=%0d exp=16", valid_cycles - v0); else n_pass++;
      send_byte(8'h41);
      n_total++; if (overrun !== 1'b1) $display("FAIL timeout_overrun got=%b exp=1", overrun); else n_pass++;
      get_byte(0, b, ok, st);
      n_total++; if (!ok || b !== 8'h15) $display("FAIL timeout_reply got=%h ok=%0d exp=15", b, ok); else n_pass++;
      @(negedge clk);
      n_total++; if (busy !== 1'b0 || tx_valid !== 1'b0) $display("FAIL timeout_idle got=%b/%b exp=0/0", busy, tx_valid); else n_pass++;
      resp_en = 1'b1;
   endtask

   task automatic test_reset_mid();
      byte_q_t f;
      int n = 0;
      resp_en = 1'b0;
      f = '{8'h57, 8'h10, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
      send_frame(f);
      while (mem_valid !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      #1 resetn = 1'b0;
      #1;
      n_total++; if (mem_valid !== 1'b0 || busy !== 1'b0) $display("FAIL midreset_drop got=%b/%b exp=0/0", mem_valid, busy); else n_pass++;
      n_total++; if (overrun !== 1'b0) $display("FAIL midreset_overrun got=%b exp=0", overrun); else n_pass++;
      @(negedge clk);
      resetn = 1'b1;
      resp_en = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_rx_timeout();
      byte_q_t f;
      logic [7:0] b;
      logic [7:0] exp_b [4] = '{8'h0D, 8'hF0, 8'hFE, 8'hCA};
      bit ok, st;
      bit saw_tx = 1'b0;
      f = '{8'h52, 8'h00};
      send_frame(f);
      repeat (150) begin
         @(negedge clk);
         if (tx_valid === 1'b1) saw_tx = 1'b1;
      end
      n_total++; if (busy !== 1'b0) $display("FAIL rxto_busy got=%b exp=0", busy); else n_pass++;
      n_total++; if (saw_tx) $display("FAIL rxto_no_reply got=tx exp=none"); else n_pass++;
      resp_rdata = 32'hCAFE_F00D;
      f = '{8'h52, 8'h08, 8'h00, 8'h00, 8'h00};
      send_frame(f);
      for (int i = 0; i < 4; i++) begin
         get_byte(0, b, ok, st);
         n_total++; if (!ok || b !== exp_b[i]) $display("FAIL rxto_read_byte%0d got=%h ok=%0d exp=%h", i, b, ok, exp_b[i]); else n_pass++;
      end
      n_total++; if (log_addr !== 32'h0000_0008) $display("FAIL rxto_read_addr got=%h exp=00000008", log_addr); else n_pass++;
   endtask

`ifdef UART_BRIDGE_AUTOINC_EN
   task automatic test_autoinc();
      byte_q_t f;
      logic [7:0] b;
      bit ok, st;
      f = '{8'h57, 8'hFC, 8'hFF, 8'hFF, 8'hFF, 8'h44, 8'h33, 8'h22, 8'h11};
      send_frame(f);
      get_byte(0, b, ok, st);
      n_total++; if (!ok || b !== 8'h06 || log_addr !== 32'hFFFF_FFFC) $display("FAIL autoinc_base got=%h/%h exp=06/fffffffc", b, log_addr); else n_pass++;
      f = '{8'h4E, 8'h01, 8'h00, 8'h00, 8'h00};
      send_frame(f);
      get_byte(0, b, ok, st);
      n_total++; if (!ok || b !== 8'h06) $display("FAIL autoinc_reply got=%h ok=%0d exp=06", b, ok); else n_pass++;
      n_total++; if (log_addr !== 32'h0000_0000) $display("FAIL autoinc_addr got=%h exp=00000000", log_addr); else n_pass++;
      n_total++; if (log_wdata !== 32'h0000_0001 || log_wstrb !== 4'hF) $display("FAIL autoinc_data got=%h/%h exp=00000001/f", log_wdata, log_wstrb); else n_pass++;
   endtask
`else
   task automatic test_n_unknown();
      logic [7:0] b;
      bit ok, st;
      int v0 = valid_cycles;
      send_byte(8'h4E);
      get_byte(0, b, ok, st);
      n_total++; if (!ok || b !== 8'h15) $display("FAIL n_cmd_reply got=%h ok=%0d exp=15", b, ok); else n_pass++;
      n_total++; if (valid_cycles - v0 !== 0) $display("FAIL n_cmd_no_bus got=%0d exp=0", valid_cycles - v0); else n_pass++;
   endtask
`endif

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired before completion");
      $fatal(1);
   end

   initial begin
      @(negedge clk);
      test_reset();
      test_write();
      test_read();
      test_unknown();
      test_addr_mask();
      test_bus_timeout();
      test_reset_mid();
      test_rx_timeout();
`ifdef UART_BRIDGE_AUTOINC_EN
      test_autoinc();
`else
      test_n_unknown();
`endif
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
